id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage directly downstream of the 32x32 register file.
- Drives the register-file read addresses and captures the read data, with forwarding from EX/MEM/WB.
- Detects RAW and load-use hazards, inserts bubbles, and holds the ID/EX pipeline register feeding the ALU.

Parameters:
WIDTH, 32, datapath/register width
CTRL_W, 16, width of opaque decoded control bundle passed to EX

Ports:
clk  in  1  clock, all state on posedge
rstn  in  1  synchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_ready  out  1  stage accepts ID instruction this cycle (combinational)
id_pc  in  WIDTH  instruction PC
id_rs1  in  5  source reg 1
id_rs2  in  5  source reg 2
id_rd  in  5  destination reg
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_imm  in  WIDTH  decoded immediate
id_ctrl  in  CTRL_W  decoded control bundle
rf_ra0  out  5  register file read address 0 (= id_rs1)
rf_ra1  out  5  register file read address 1 (= id_rs2)
rf_rd0  in  WIDTH  register file read data 0
rf_rd1  in  WIDTH  register file read data 1
ex_result  in  WIDTH  ALU result of instruction currently in EX
mem_valid, mem_we  in  1,1  MEM-stage instruction valid / writes rd
mem_rd  in  5  MEM-stage destination
mem_data  in  WIDTH  MEM-stage final result (load data or ALU result)
wb_valid, wb_we  in  1,1  WB-stage valid / writes (same signals driving regfile we)
wb_rd  in  5  WB destination
wb_data  in  WIDTH  WB data
flush  in  1  kill ID and EX contents (taken branch/jump)
ex_hold  in  1  downstream EX busy; freeze this stage
ex_valid  out  1  ID/EX register valid
ex_pc, ex_imm, ex_op1, ex_op2  out  WIDTH each  latched PC, immediate, resolved operands
ex_rd  out  5  latched destination
ex_we, ex_is_load  out  1,1  latched write-enable / load flag
ex_ctrl  out  CTRL_W  latched control
stall_cnt  out  32  saturating count of bubble cycles inserted

Behaviour:
- Reset (rstn=0 at posedge): all ex_* outputs = 0, stall_cnt = 0; id_ready = 0 while rstn = 0.
- Match rule: source r matches stage S iff r != 0, S valid, S we, and S rd == r. x0 never hazards; its operand is always 0.
- Operand resolution (FWD_EN), per source, priority EX > MEM > WB > regfile:
  - EX = the ID/EX register contents; an EX match takes ex_result.
  - A WB match is needed because regfile writes at the edge.
- Load-use: EX match with ex_is_load = 1 -> stall.
- Per-cycle priority at posedge: rstn low > flush > ex_hold > stall > advance.
  - flush: ex_valid <= 0; id_ready = 1 (ID instruction discarded upstream); stall_cnt unchanged.
  - ex_hold (no flush): all ex_* hold; id_ready = 0.
  - stall: insert bubble (ex_valid <= 0, ex_we <= 0, other ex_* don't-care); id_ready = 0; stall_cnt += 1, saturating at 0xFFFFFFFF.
  - advance: ex_* <= ID fields and resolved operands, ex_valid <= id_valid; id_ready = 1.
- id_valid = 0 with no stall: bubble latched, no stall_cnt increment.
- Hazard checks use only the id_rs fields; instructions that don't read a source must drive that field 0.
- Latency: one cycle ID -> EX; stall adds exactly one cycle per load-use.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding as above.
- Undefined: no bypass muxes; any match with EX, MEM or WB stalls until cleared; operands always from rf_rd0/rf_rd1.
- Worst case without forwarding: 3 bubbles for back-to-back dependents.

Decomposition:
- Shared package cpu_pkg: REG_ADDR_W=5, XLEN=32, ZERO_REG=5'd0, ctrl bundle width.
- One combinational sub-module hazard_fwd_unit: match compares, forward select, stall decision. The top keeps the registers and stall_cnt.

Test Plan:
- Reset: rstn=0 two cycles -> ex_valid=0, all ex_* = 0, stall_cnt=0, id_ready=0.
- EX forward (FWD_EN): add x5 in EX with ex_result=0x11, ID reads rs1=x5 -> next cycle ex_op1=0x11, no stall.
- Load-use: lw x6 in EX, ID rs2=x6 -> one bubble (ex_valid=0), stall_cnt=1; following cycle ex_op2=mem_data=0xDEADBEEF.
- x0 and WB bypass:
  - ID rs1=x0 while MEM writes x0 with 0x55 -> ex_op1=0.
  - WB writes x7=0x7 same cycle ID reads x7 -> ex_op1=0x7.
- Flush priority: flush=1 together with a load-use stall and ex_hold=1 -> ex_valid=0, id_ready=1, stall_cnt unchanged.
- Without ID_EX_FWD_EN: back-to-back dependent add -> 3 bubbles, stall_cnt=3, then ex_op1 = regfile value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the ID/EX slice: register-file geometry,
// control bundle width, operand-source and stage-action encodings, and
// the common register-match helper used by the hazard unit.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Where a resolved source operand comes from.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    // What the ID/EX register does on the coming clock edge.
    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_STALL   = 2'd2,
        ACT_ADVANCE = 2'd3
    } stage_act_e;

    // A source register depends on a later stage only if it is a real
    // register (x0 never hazards) and that stage holds a valid writer of it.
    function automatic logic regMatch(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  stageValid,
        input logic                  stageWe,
        input logic [REG_ADDR_W-1:0] stageRd
    );
        return (src != ZERO_REG) && stageValid && stageWe && (stageRd == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational hazard detection and operand forwarding for the ID stage.
// Build option: define ID_EX_FWD_EN to enable the EX/MEM/WB bypass muxes;
// without it every dependency on an in-flight writer stalls until retired
// and operands always come straight from the register file.
module hazard_fwd_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic                  idValid_i,
    input  logic [REG_ADDR_W-1:0] idRs1_i,
    input  logic [REG_ADDR_W-1:0] idRs2_i,
    input  logic                  exValid_i,
    input  logic                  exWe_i,
    input  logic                  exIsLoad_i,
    input  logic [REG_ADDR_W-1:0] exRd_i,
    input  logic [WIDTH-1:0]      exResult_i,
    input  logic                  memValid_i,
    input  logic                  memWe_i,
    input  logic [REG_ADDR_W-1:0] memRd_i,
    input  logic [WIDTH-1:0]      memData_i,
    input  logic                  wbValid_i,
    input  logic                  wbWe_i,
    input  logic [REG_ADDR_W-1:0] wbRd_i,
    input  logic [WIDTH-1:0]      wbData_i,
    input  logic [WIDTH-1:0]      rfRd0_i,
    input  logic [WIDTH-1:0]      rfRd1_i,
    output logic [WIDTH-1:0]      op1_o,
    output logic [WIDTH-1:0]      op2_o,
    output logic                  stall_o
);

    logic exMatch1, memMatch1, wbMatch1;
    logic exMatch2, memMatch2, wbMatch2;

    assign exMatch1  = regMatch(idRs1_i, exValid_i,  exWe_i,  exRd_i);
    assign memMatch1 = regMatch(idRs1_i, memValid_i, memWe_i, memRd_i);
    assign wbMatch1  = regMatch(idRs1_i, wbValid_i,  wbWe_i,  wbRd_i);
    assign exMatch2  = regMatch(idRs2_i, exValid_i,  exWe_i,  exRd_i);
    assign memMatch2 = regMatch(idRs2_i, memValid_i, memWe_i, memRd_i);
    assign wbMatch2  = regMatch(idRs2_i, wbValid_i,  wbWe_i,  wbRd_i);

`ifdef ID_EX_FWD_EN

    fwd_sel_e sel1, sel2;

    // Pick the youngest in-flight producer for each source: EX, then MEM, then WB.
    always_comb begin
        sel1 = FWD_RF;
        sel2 = FWD_RF;
        if (exMatch1)       sel1 = FWD_EX;
        else if (memMatch1) sel1 = FWD_MEM;
        else if (wbMatch1)  sel1 = FWD_WB;
        if (exMatch2)       sel2 = FWD_EX;
        else if (memMatch2) sel2 = FWD_MEM;
        else if (wbMatch2)  sel2 = FWD_WB;
    end

    // Operand muxes; x0 reads as zero regardless of what any stage claims.
    always_comb begin
        op1_o = rfRd0_i;
        op2_o = rfRd1_i;
        case (sel1)
            FWD_EX:  op1_o = exResult_i;
            FWD_MEM: op1_o = memData_i;
            FWD_WB:  op1_o = wbData_i;
            default: op1_o = rfRd0_i;
        endcase
        case (sel2)
            FWD_EX:  op2_o = exResult_i;
            FWD_MEM: op2_o = memData_i;
            FWD_WB:  op2_o = wbData_i;
            default: op2_o = rfRd1_i;
        endcase
        if (idRs1_i == ZERO_REG) op1_o = '0;
        if (idRs2_i == ZERO_REG) op2_o = '0;
    end

    // Only a load in EX cannot be bypassed: its data is not ready until MEM.
    always_comb begin
        stall_o = idValid_i && exIsLoad_i && (exMatch1 || exMatch2);
    end

`else

    logic unusedBits;
    assign unusedBits = ^{exIsLoad_i, exResult_i, memData_i, wbData_i};

    // Without bypassing the register file is the only source; x0 reads as zero.
    always_comb begin
        op1_o = (idRs1_i == ZERO_REG) ? '0 : rfRd0_i;
        op2_o = (idRs2_i == ZERO_REG) ? '0 : rfRd1_i;
    end

    // Any in-flight writer of a source blocks issue until it has retired.
    always_comb begin
        stall_o = idValid_i && (exMatch1 || memMatch1 || wbMatch1 ||
                                exMatch2 || memMatch2 || wbMatch2);
    end

`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: drives register-file read addresses, resolves
// operands through hazard_fwd_unit, and holds the ID/EX register feeding
// the ALU. Per-edge priority is reset > flush > ex_hold > stall > advance.
// Build option: ID_EX_FWD_EN enables EX/MEM/WB forwarding (see hazard_fwd_unit).
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [WIDTH-1:0]      id_pc,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic [4:0]            id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic [WIDTH-1:0]      id_imm,
    input  logic [CTRL_W-1:0]     id_ctrl,
    output logic [4:0]            rf_ra0,
    output logic [4:0]            rf_ra1,
    input  logic [WIDTH-1:0]      rf_rd0,
    input  logic [WIDTH-1:0]      rf_rd1,
    input  logic [WIDTH-1:0]      ex_result,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic [4:0]            mem_rd,
    input  logic [WIDTH-1:0]      mem_data,
    input  logic                  wb_valid,
    input  logic                  wb_we,
    input  logic [4:0]            wb_rd,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic                  flush,
    input  logic                  ex_hold,
    output logic                  ex_valid,
    output logic [WIDTH-1:0]      ex_pc,
    output logic [WIDTH-1:0]      ex_imm,
    output logic [WIDTH-1:0]      ex_op1,
    output logic [WIDTH-1:0]      ex_op2,
    output logic [4:0]            ex_rd,
    output logic                  ex_we,
    output logic                  ex_is_load,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [31:0]           stall_cnt
);

    logic              exValid_q,  exValid_d;
    logic [WIDTH-1:0]  exPc_q,     exPc_d;
    logic [WIDTH-1:0]  exImm_q,    exImm_d;
    logic [WIDTH-1:0]  exOp1_q,    exOp1_d;
    logic [WIDTH-1:0]  exOp2_q,    exOp2_d;
    logic [4:0]        exRd_q,     exRd_d;
    logic              exWe_q,     exWe_d;
    logic              exIsLoad_q, exIsLoad_d;
    logic [CTRL_W-1:0] exCtrl_q,   exCtrl_d;
    logic [31:0]       stallCnt_q, stallCnt_d;

    logic [WIDTH-1:0]  resolvedOp1, resolvedOp2;
    logic              hazardStall;
    stage_act_e        action;

    assign rf_ra0 = id_rs1;
    assign rf_ra1 = id_rs2;

    hazard_fwd_unit #(
        .WIDTH (WIDTH)
    ) uHazard (
        .idValid_i  (id_valid),
        .idRs1_i    (id_rs1),
        .idRs2_i    (id_rs2),
        .exValid_i  (exValid_q),
        .exWe_i     (exWe_q),
        .exIsLoad_i (exIsLoad_q),
        .exRd_i     (exRd_q),
        .exResult_i (ex_result),
        .memValid_i (mem_valid),
        .memWe_i    (mem_we),
        .memRd_i    (mem_rd),
        .memData_i  (mem_data),
        .wbValid_i  (wb_valid),
        .wbWe_i     (wb_we),
        .wbRd_i     (wb_rd),
        .wbData_i   (wb_data),
        .rfRd0_i    (rf_rd0),
        .rfRd1_i    (rf_rd1),
        .op1_o      (resolvedOp1),
        .op2_o      (resolvedOp2),
        .stall_o    (hazardStall)
    );

    // Decide this cycle's action; flush outranks a downstream hold, which outranks a hazard.
    always_comb begin
        action = ACT_ADVANCE;
        if (flush)            action = ACT_FLUSH;
        else if (ex_hold)     action = ACT_HOLD;
        else if (hazardStall) action = ACT_STALL;
    end

    // ID may hand over its instruction when it is either consumed or discarded by a flush.
    always_comb begin
        id_ready = rstn && ((action == ACT_FLUSH) || (action == ACT_ADVANCE));
    end

    // Next-state of the ID/EX register and the saturating bubble counter.
    always_comb begin
        exValid_d  = exValid_q;
        exPc_d     = exPc_q;
        exImm_d    = exImm_q;
        exOp1_d    = exOp1_q;
        exOp2_d    = exOp2_q;
        exRd_d     = exRd_q;
        exWe_d     = exWe_q;
        exIsLoad_d = exIsLoad_q;
        exCtrl_d   = exCtrl_q;
        stallCnt_d = stallCnt_q;
        case (action)
            ACT_FLUSH: begin
                exValid_d = 1'b0;
            end
            ACT_HOLD: begin
                exValid_d = exValid_q;
            end
            ACT_STALL: begin
                exValid_d = 1'b0;
                exWe_d    = 1'b0;
                if (stallCnt_q != 32'hFFFF_FFFF) stallCnt_d = stallCnt_q + 32'd1;
            end
            default: begin
                exValid_d  = id_valid;
                exPc_d     = id_pc;
                exImm_d    = id_imm;
                exOp1_d    = resolvedOp1;
                exOp2_d    = resolvedOp2;
                exRd_d     = id_rd;
                exWe_d     = id_we;
                exIsLoad_d = id_is_load;
                exCtrl_d   = id_ctrl;
            end
        endcase
    end

    // ID/EX register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            exValid_q  <= 1'b0;
            exPc_q     <= '0;
            exImm_q    <= '0;
            exOp1_q    <= '0;
            exOp2_q    <= '0;
            exRd_q     <= '0;
            exWe_q     <= 1'b0;
            exIsLoad_q <= 1'b0;
            exCtrl_q   <= '0;
            stallCnt_q <= '0;
        end else begin
            exValid_q  <= exValid_d;
            exPc_q     <= exPc_d;
            exImm_q    <= exImm_d;
            exOp1_q    <= exOp1_d;
            exOp2_q    <= exOp2_d;
            exRd_q     <= exRd_d;
            exWe_q     <= exWe_d;
            exIsLoad_q <= exIsLoad_d;
            exCtrl_q   <= exCtrl_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign ex_valid   = exValid_q;
    assign ex_pc      = exPc_q;
    assign ex_imm     = exImm_q;
    assign ex_op1     = exOp1_q;
    assign ex_op2     = exOp2_q;
    assign ex_rd      = exRd_q;
    assign ex_we      = exWe_q;
    assign ex_is_load = exIsLoad_q;
    assign ex_ctrl    = exCtrl_q;
    assign stall_cnt  = stallCnt_q;

endmodule
